mult_ctrl_unit: RTL and testbench

- Sequential shift-add controller for an 8x8 two's-complement multiplier.
- Owns the X/A/B/S registers and sequences a 9-bit add/subtract unit over 8 iterations.
- Produces a 16-bit signed product in {A,B}, with X holding the sign extension.
- Sits between the board switch/button inputs and the hex-display drivers in the multiplier top level.

---
 rtl/mult_pkg.sv | 22 ++
 rtl/mult_ctrl_unit_addsub.sv | 30 +++
 rtl/mult_ctrl_unit.sv | 137 +++++++++++++
 tb/tb_mult_ctrl_unit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the shift-add multiplier
//
// Purpose: FSM state encoding, operand width and last-iteration index used by
// mult_ctrl_unit and its add/sub unit.
// Ports: none (package).

package mult_pkg;

  localparam int WIDTH = 8;

  // Index of the final iteration; the partial product is subtracted here
  // because the multiplier's bit 7 carries negative weight.
  localparam logic [2:0] LAST_ITER = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } mult_state_t;

endpackage

// File: rtl/mult_ctrl_unit_addsub.sv
// rtl/mult_ctrl_unit_addsub.sv - 9-bit sign-extending adder/subtractor
//
// Purpose: S = A + B, or A - B when Subtract is high. Both operands are
// sign-extended to 9 bits, so the result never overflows.
// Ports:
//   A        in  8  left operand (two's complement)
//   B        in  8  right operand (two's complement)
//   Subtract in  1  1 selects A - B, 0 selects A + B
//   S        out 9  sign-extended result

module mult_ctrl_unit_addsub (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Subtract,
  output logic [8:0] S
);

  logic [8:0] a_ext;
  logic [8:0] b_ext;
  logic [8:0] b_op;

  always_comb begin
    a_ext = {A[7], A};
    b_ext = {B[7], B};
    // Subtraction as A + ~B + 1.
    b_op  = Subtract ? ~b_ext : b_ext;
    S     = a_ext + b_op + {8'd0, Subtract};
  end

endmodule

// File: rtl/mult_ctrl_unit.sv
// rtl/mult_ctrl_unit.sv - sequential shift-add controller for an 8x8 signed multiplier
//
// Purpose: owns the X/A/B/S registers and steps the add/sub unit through 8
// ADD/SHIFT iterations, leaving the 16-bit signed product in {A,B} with X as
// the sign extension.
// Ports:
//   Clk          in  1  system clock, rising edge
//   Reset        in  1  synchronous active-high reset
//   Run          in  1  start request (level; one multiply per high period)
//   ClearA_LoadB in  1  in IDLE: B <= Switches, A <= 0, X <= 0
//   Switches     in  8  multiplier at load time, multiplicand at start time
//   Aval         out 8  register A (product high byte)
//   Bval         out 8  register B (product low byte)
//   Xval         out 1  sign-extension bit X
//   Busy         out 1  high in ADD and SHIFT
//   Done         out 1  high in HOLD

module mult_ctrl_unit #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] Switches,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Xval,
  output logic             Busy,
  output logic             Done
);

  import mult_pkg::*;

  // The add/sub unit is fixed at 8 bits in, 9 bits out.
  if (WIDTH != mult_pkg::WIDTH) begin : g_width_check
    $error("mult_ctrl_unit: only WIDTH=8 is supported");
  end

  mult_state_t      state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             x_q, x_d;
  logic [2:0]       count_q, count_d;

  logic             last_iter;
  logic [WIDTH:0]   sum;

  assign last_iter = (count_q == LAST_ITER);

  mult_ctrl_unit_addsub u_addsub (
    .A        (a_q),
    .B        (s_q),
    .Subtract (last_iter),
    .S        (sum)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      x_q     <= 1'b0;
      count_q <= 3'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      x_q     <= x_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    x_d     = x_q;
    count_d = count_q;

    unique case (state_q)
      IDLE: begin
        // Run beats ClearA_LoadB: B keeps the loaded multiplier.
        if (Run) begin
          s_d     = Switches;
          a_d     = '0;
          x_d     = 1'b0;
          count_d = 3'd0;
          state_d = ADD;
        end else if (ClearA_LoadB) begin
          b_d = Switches;
          a_d = '0;
          x_d = 1'b0;
        end
      end

      ADD: begin
        if (b_q[0]) begin
          {x_d, a_d} = sum;
        end
        state_d = SHIFT;
      end

      SHIFT: begin
        // Arithmetic right shift of {X,A,B}; X replicates itself.
        a_d = {x_q, a_q[WIDTH-1:1]};
        b_d = {a_q[0], b_q[WIDTH-1:1]};
        if (last_iter) begin
          state_d = HOLD;
        end else begin
          count_d = count_q + 3'd1;
          state_d = ADD;
        end
      end

      HOLD: begin
        // Waiting for Run to fall is what makes a held Run a single multiply.
        if (!Run) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign Xval = x_q;
  assign Busy = (state_q == ADD) || (state_q == SHIFT);
  assign Done = (state_q == HOLD);

endmodule

// File: tb/tb_mult_ctrl_unit.sv
// tb/tb_mult_ctrl_unit.sv - directed self-checking bench for mult_ctrl_unit

module tb_mult_ctrl_unit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Run;
  logic       ClearA_LoadB;
  logic [7:0] Switches;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic       Xval;
  logic       Busy;
  logic       Done;

  int checks   = 0;
  int failures = 0;

  mult_ctrl_unit #(.WIDTH(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .Switches     (Switches),
    .Aval         (Aval),
    .Bval         (Bval),
    .Xval         (Xval),
    .Busy         (Busy),
    .Done         (Done)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  // load: preload B with b first; both: raise ClearA_LoadB alongside Run
  // (b is then the B value already held); scramble: randomise Switches
  // every busy cycle.
  task automatic do_mult(input bit load, input bit both, input bit scramble,
                         input logic [7:0] b, input logic [7:0] s,
                         input logic [15:0] exp_prod, input logic exp_x,
                         input string tag);
    int n;
    if (load) begin
      Switches     = b;
      ClearA_LoadB = 1'b1;
      tick();
      ClearA_LoadB = 1'b0;
      check({tag, "_loadB"}, {8'd0, Bval}, {8'd0, b});
    end
    Switches     = s;
    Run          = 1'b1;
    ClearA_LoadB = both;
    tick();
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    check({tag, "_busy"}, {15'd0, Busy}, 16'd1);
    if (both) check({tag, "_noreload"}, {8'd0, Bval}, {8'd0, b});
    n = 0;
    while (!Done && n < 40) begin
      if (scramble) Switches = 8'($urandom);
      tick();
      n++;
    end
    check({tag, "_cycles"}, 16'(n), 16'd16);
    check({tag, "_prod"}, {Aval, Bval}, exp_prod);
    check({tag, "_x"}, {15'd0, Xval}, {15'd0, exp_x});
    tick();
    check({tag, "_idle"}, {15'd0, Done}, 16'd0);
  endtask

  initial begin
    Reset        = 1'b1;
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    Switches     = 8'h00;
    tick();
    tick();
    Reset = 1'b0;
    check("rst_ab", {Aval, Bval}, 16'h0000);
    check("rst_x", {15'd0, Xval}, 16'd0);
    check("rst_busy", {15'd0, Busy}, 16'd0);
    check("rst_done", {15'd0, Done}, 16'd0);

    do_mult(1, 0, 0, 8'h03, 8'h07, 16'h0015, 1'b0, "m7x3");
    do_mult(1, 0, 0, 8'hFD, 8'h05, 16'hFFF1, 1'b1, "m_3x5");
    do_mult(1, 0, 0, 8'hFF, 8'hFF, 16'h0001, 1'b0, "m_1x_1");
    // B holds 0x01 from the previous product; reloading would give 6*6.
    do_mult(0, 1, 0, 8'h01, 8'h06, 16'h0006, 1'b0, "both");
    do_mult(1, 0, 0, 8'h80, 8'h80, 16'h4000, 1'b0, "m128");
    do_mult(1, 0, 1, 8'h03, 8'h07, 16'h0015, 1'b0, "scram");

    // Run held high: one multiply, then parked in HOLD.
    Switches     = 8'h03;
    ClearA_LoadB = 1'b1;
    tick();
    ClearA_LoadB = 1'b0;
    Switches     = 8'h07;
    Run          = 1'b1;
    repeat (40) tick();
    check("hold_done", {15'd0, Done}, 16'd1);
    check("hold_prod", {Aval, Bval}, 16'h0015);
    Switches = 8'hAA;
    repeat (4) begin
      ClearA_LoadB = ~ClearA_LoadB;
      tick();
    end
    ClearA_LoadB = 1'b0;
    check("hold_frozen", {Aval, Bval}, 16'h0015);
    check("hold_still", {15'd0, Done}, 16'd1);
    Run = 1'b0;
    tick();
    check("hold_exit_done", {15'd0, Done}, 16'd0);
    check("hold_exit_busy", {15'd0, Busy}, 16'd0);

    // Reset at busy cycle 9.
    Switches     = 8'h03;
    ClearA_LoadB = 1'b1;
    tick();
    ClearA_LoadB = 1'b0;
    Switches     = 8'h07;
    Run          = 1'b1;
    tick();
    Run = 1'b0;
    repeat (8) tick();
    check("mid_busy", {15'd0, Busy}, 16'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mid_rst_ab", {Aval, Bval}, 16'h0000);
    check("mid_rst_x", {15'd0, Xval}, 16'd0);
    check("mid_rst_busy", {15'd0, Busy}, 16'd0);
    check("mid_rst_done", {15'd0, Done}, 16'd0);
    do_mult(1, 0, 0, 8'hFD, 8'h05, 16'hFFF1, 1'b1, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
